// File: rtl/cr_xp10_decomp_be_frm_tag.sv
// XP10 decompressor back-end frame tagger: delays the LZ back-end word stream by
// two cycles so the frame checker's size/crc pulses line up with the frame-end
// word, tags that word with an error bit and queues one status record per frame.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   lz_be_dp_*                 LZ back-end word (valid/data/bytes_valid/data_type)
//   lfa_be_crc_valid           trailer record written into the checker's FIFO
//   size_error, crc_error      checker result pulses, aligned to the S2 word
//   out_*                      word delayed by two cycles
//   out_err                    frame-end word whose frame failed
//   stat_valid/stat_ready      status FIFO handshake
//   stat_frm_num/bcnt/code     head status record {frame, bytes, code}
//   stat_overflow              sticky: a status record was dropped
module cr_xp10_decomp_be_frm_tag #(
    parameter int STAT_DEPTH = 4,
    parameter int TRL_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lz_be_dp_valid,
    input  logic [63:0] lz_be_dp_data,
    input  logic [7:0]  lz_be_dp_bytes_valid,
    input  logic [1:0]  lz_be_dp_data_type,
    input  logic        lfa_be_crc_valid,
    input  logic        size_error,
    input  logic        crc_error,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic [7:0]  out_bytes_valid,
    output logic [1:0]  out_data_type,
    output logic        out_err,
    output logic        stat_valid,
    input  logic        stat_ready,
    output logic [15:0] stat_frm_num,
    output logic [31:0] stat_bcnt,
    output logic [2:0]  stat_code,
    output logic        stat_overflow
);

    localparam int PW = $clog2(STAT_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TRL_DEPTH + 1);
    localparam logic [TW-1:0] TRL_MAX   = TW'(TRL_DEPTH);
    localparam logic [CW-1:0] STAT_FULL = CW'(STAT_DEPTH);

    logic        s1_valid;
    logic [63:0] s1_data;
    logic [7:0]  s1_bytes;
    logic [1:0]  s1_type;

    logic        s2_valid;
    logic [63:0] s2_data;
    logic [7:0]  s2_bytes;
    logic [1:0]  s2_type;
    logic [31:0] s2_bcnt;
    logic        s2_missing;

    logic [31:0]   bcnt;
    logic [TW-1:0] trl_cnt;
    logic [15:0]   frm_num;

    logic [50:0]   stat_mem [STAT_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] stat_cnt;
    logic          ovf;

    logic        s1_fe;
    logic        s1_pay;
    logic        s2_fe;
    logic        trl_zero;
    logic        trl_dec;
    logic [2:0]  code;
    logic        push;
    logic        pop;
    logic        full;
    logic        wr_en;
    logic [3:0]  pcnt;

    // Only a clean thermometer mask counts; anything else contributes nothing.
    function automatic logic [3:0] therm_cnt(input logic [7:0] m);
        case (m)
            8'h01:   return 4'd1;
            8'h03:   return 4'd2;
            8'h07:   return 4'd3;
            8'h0F:   return 4'd4;
            8'h1F:   return 4'd5;
            8'h3F:   return 4'd6;
            8'h7F:   return 4'd7;
            8'hFF:   return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    always_comb begin
        s1_fe    = s1_valid & (s1_type != 2'b01);
        s1_pay   = s1_valid & (s1_type == 2'b01);
        s2_fe    = s2_valid & (s2_type != 2'b01);
        trl_zero = (trl_cnt == '0);
        trl_dec  = s1_fe & ~trl_zero;
        pcnt     = therm_cnt(s1_bytes);
        // No trailer means the checker skipped this frame: its pulses are stale.
        code     = s2_missing ? 3'b100 : {1'b0, size_error, crc_error};
        out_err  = s2_fe & (|code);
        push     = s2_fe;
        pop      = stat_valid & stat_ready;
        full     = (stat_cnt == STAT_FULL);
        wr_en    = push & (~full | pop);
    end

    assign out_valid       = s2_valid;
    assign out_data        = s2_data;
    assign out_bytes_valid = s2_bytes;
    assign out_data_type   = s2_type;
    assign stat_valid      = (stat_cnt != '0);
    assign {stat_frm_num, stat_bcnt, stat_code} = stat_mem[rd_ptr];
    assign stat_overflow   = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_bytes   <= '0;
            s1_type    <= '0;
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            s2_bytes   <= '0;
            s2_type    <= '0;
            s2_bcnt    <= '0;
            s2_missing <= 1'b0;
            bcnt       <= '0;
        end else begin
            s1_valid   <= lz_be_dp_valid;
            s1_data    <= lz_be_dp_data;
            s1_bytes   <= lz_be_dp_bytes_valid;
            s1_type    <= lz_be_dp_data_type;
            s2_valid   <= s1_valid;
            s2_data    <= s1_data;
            s2_bytes   <= s1_bytes;
            s2_type    <= s1_type;
            s2_bcnt    <= s1_fe ? bcnt : '0;
            s2_missing <= s1_fe & trl_zero;
            if (s1_fe) begin
                bcnt <= '0;
            end else if (s1_pay) begin
                bcnt <= bcnt + {28'd0, pcnt};
            end
        end
    end

    // Trailer mirror: simultaneous write and consume cancel even when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trl_cnt <= '0;
        end else if (lfa_be_crc_valid & ~trl_dec) begin
            if (trl_cnt != TRL_MAX) begin
                trl_cnt <= trl_cnt + 1'b1;
            end
        end else if (~lfa_be_crc_valid & trl_dec) begin
            trl_cnt <= trl_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAT_DEPTH; i++) begin
                stat_mem[i] <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            stat_cnt <= '0;
            ovf      <= 1'b0;
            frm_num  <= '0;
        end else begin
            if (wr_en) begin
                stat_mem[wr_ptr] <= {frm_num, s2_bcnt, code};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en & ~pop) begin
                stat_cnt <= stat_cnt + 1'b1;
            end else if (~wr_en & pop) begin
                stat_cnt <= stat_cnt - 1'b1;
            end
            if (push & ~wr_en) begin
                ovf <= 1'b1;
            end
            // Frame numbers advance even for dropped records.
            if (push) begin
                frm_num <= frm_num + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cr_xp10_decomp_be_frm_tag.sv
// Directed bench for cr_xp10_decomp_be_frm_tag with a word-order model that is
// checked against the DUT on every cycle.
module tb_cr_xp10_decomp_be_frm_tag;

    localparam int SD = 4;
    localparam int TD = 8;
    localparam int HM = 2047;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lz_be_dp_valid;
    logic [63:0] lz_be_dp_data;
    logic [7:0]  lz_be_dp_bytes_valid;
    logic [1:0]  lz_be_dp_data_type;
    logic        lfa_be_crc_valid;
    logic        size_error;
    logic        crc_error;
    logic        out_valid;
    logic [63:0] out_data;
    logic [7:0]  out_bytes_valid;
    logic [1:0]  out_data_type;
    logic        out_err;
    logic        stat_valid;
    logic        stat_ready;
    logic [15:0] stat_frm_num;
    logic [31:0] stat_bcnt;
    logic [2:0]  stat_code;
    logic        stat_overflow;

    cr_xp10_decomp_be_frm_tag #(.STAT_DEPTH(SD), .TRL_DEPTH(TD)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .lz_be_dp_valid       (lz_be_dp_valid),
        .lz_be_dp_data        (lz_be_dp_data),
        .lz_be_dp_bytes_valid (lz_be_dp_bytes_valid),
        .lz_be_dp_data_type   (lz_be_dp_data_type),
        .lfa_be_crc_valid     (lfa_be_crc_valid),
        .size_error           (size_error),
        .crc_error            (crc_error),
        .out_valid            (out_valid),
        .out_data             (out_data),
        .out_bytes_valid      (out_bytes_valid),
        .out_data_type        (out_data_type),
        .out_err              (out_err),
        .stat_valid           (stat_valid),
        .stat_ready           (stat_ready),
        .stat_frm_num         (stat_frm_num),
        .stat_bcnt            (stat_bcnt),
        .stat_code            (stat_code),
        .stat_overflow        (stat_overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model state, indexed by the cycle each word was presented.
    bit          hv    [2048];
    logic [63:0] hd    [2048];
    logic [7:0]  hm    [2048];
    logic [1:0]  ht    [2048];
    bit          hmiss [2048];
    logic [31:0] hb    [2048];
    int          m_trl  = 0;
    logic [31:0] m_bcnt = '0;
    logic [15:0] m_frm  = '0;
    bit          m_ovf  = 1'b0;
    logic [50:0] mq [$];
    logic [50:0] got [$];
    int          kc = 1;
    int          i0, i1, i2;
    bit          fe2;
    logic [2:0]  ecode;

    function automatic int therm(input logic [7:0] m);
        for (int n = 1; n <= 8; n++) begin
            if (m == 8'((9'h1 << n) - 9'h1)) return n;
        end
        return 0;
    endfunction

    always @(negedge clk) begin
        kc++;
        i0 = kc & HM;
        i1 = (kc - 1) & HM;
        i2 = (kc - 2) & HM;
        if (!rst_n) begin
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_out_data", out_data, 64'd0);
            chk("rst_out_err", {63'd0, out_err}, 64'd0);
            chk("rst_stat_valid", {63'd0, stat_valid}, 64'd0);
            chk("rst_stat_rec", {13'd0, stat_frm_num, stat_bcnt, stat_code}, 64'd0);
            chk("rst_overflow", {63'd0, stat_overflow}, 64'd0);
            hv[i0] = 1'b0;
            hv[i1] = 1'b0;
            m_trl  = 0;
            m_bcnt = '0;
            m_frm  = '0;
            m_ovf  = 1'b0;
            mq.delete();
        end else begin
            hv[i0]    = lz_be_dp_valid;
            hd[i0]    = lz_be_dp_data;
            hm[i0]    = lz_be_dp_bytes_valid;
            ht[i0]    = lz_be_dp_data_type;
            hmiss[i0] = 1'b0;
            hb[i0]    = '0;
            if (lfa_be_crc_valid && m_trl < TD) m_trl++;
            if (lz_be_dp_valid) begin
                if (lz_be_dp_data_type == 2'b01) begin
                    m_bcnt = m_bcnt + 32'(therm(lz_be_dp_bytes_valid));
                end else begin
                    hb[i0] = m_bcnt;
                    m_bcnt = '0;
                    if (m_trl == 0) hmiss[i0] = 1'b1;
                    else m_trl--;
                end
            end
            chk("out_valid", {63'd0, out_valid}, {63'd0, hv[i2]});
            if (hv[i2]) begin
                chk("out_data", out_data, hd[i2]);
                chk("out_bytes", {56'd0, out_bytes_valid}, {56'd0, hm[i2]});
                chk("out_type", {62'd0, out_data_type}, {62'd0, ht[i2]});
            end
            fe2 = hv[i2] && (ht[i2] != 2'b01);
            if (!fe2) ecode = 3'b000;
            else if (hmiss[i2]) ecode = 3'b100;
            else ecode = {1'b0, size_error, crc_error};
            chk("out_err", {63'd0, out_err}, {63'd0, |ecode});
            chk("stat_valid", {63'd0, stat_valid}, {63'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("stat_head", {13'd0, stat_frm_num, stat_bcnt, stat_code},
                    {13'd0, mq[0]});
            end
            chk("stat_overflow", {63'd0, stat_overflow}, {63'd0, m_ovf});
            if (mq.size() != 0 && stat_ready) begin
                got.push_back({stat_frm_num, stat_bcnt, stat_code});
                void'(mq.pop_front());
            end
            if (fe2) begin
                if (mq.size() < SD) mq.push_back({m_frm, hb[i2], ecode});
                else m_ovf = 1'b1;
                m_frm++;
            end
        end
    end

    task automatic drv(input logic v, input logic [63:0] d, input logic [7:0] m,
                       input logic [1:0] t, input logic lfa, input logic se,
                       input logic ce);
        @(posedge clk);
        #1;
        lz_be_dp_valid       = v;
        lz_be_dp_data        = d;
        lz_be_dp_bytes_valid = m;
        lz_be_dp_data_type   = t;
        lfa_be_crc_valid     = lfa;
        size_error           = se;
        crc_error            = ce;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 64'd0, 8'h00, 2'b00, 0, 0, 0);
    endtask

    task automatic chk_got(input int idx, input logic [50:0] exp);
        if (idx < got.size())
            chk($sformatf("rec%0d", idx), {13'd0, got[idx]}, {13'd0, exp});
        else
            chk($sformatf("rec%0d_count", idx), 64'(got.size()), 64'(idx + 1));
    endtask

    initial begin
        rst_n                = 1'b0;
        stat_ready           = 1'b1;
        lz_be_dp_valid       = 1'b0;
        lz_be_dp_data        = '0;
        lz_be_dp_bytes_valid = '0;
        lz_be_dp_data_type   = '0;
        lfa_be_crc_valid     = 1'b0;
        size_error           = 1'b0;
        crc_error            = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Clean frame: 8 + 3 bytes.
        drv(0, 64'd0, 8'h00, 2'b00, 1, 0, 0);
        drv(1, 64'h1111_2222_3333_4444, 8'hFF, 2'b01, 0, 0, 0);
        drv(1, 64'h0000_0000_00AB_CDEF, 8'h07, 2'b01, 0, 0, 0);
        drv(1, 64'hFEED_0000_0000_0001, 8'hFF, 2'b10, 0, 0, 0);
        idle(4);
        chk_got(0, {16'd0, 32'd11, 3'b000});

        // Same frame, crc error aligned with the delayed frame-end word.
        drv(0, 64'd0, 8'h00, 2'b00, 1, 0, 0);
        drv(1, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 2'b01, 0, 0, 0);
        drv(1, 64'h0000_0000_0012_3456, 8'h07, 2'b01, 0, 0, 0);
        drv(1, 64'hFEED_0000_0000_0002, 8'hFF, 2'b00, 0, 0, 0);
        idle(1);
        drv(0, 64'd0, 8'h00, 2'b00, 0, 0, 1);
        idle(3);
        chk_got(1, {16'd1, 32'd11, 3'b001});

        // No trailer: size error is masked, missing reported.
        drv(1, 64'hFEED_0000_0000_0003, 8'hFF, 2'b11, 0, 0, 0);
        idle(1);
        drv(0, 64'd0, 8'h00, 2'b00, 0, 1, 0);
        idle(3);
        chk_got(2, {16'd2, 32'd0, 3'b100});

        // Nine trailers saturate at eight; ninth frame has none.
        for (int i = 0; i < 9; i++) drv(0, 64'd0, 8'h00, 2'b00, 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drv(1, 64'(i), 8'h0F, 2'b01, 0, 0, 0);
            drv(1, 64'h100 + 64'(i), 8'h00, 2'b10, 0, 0, 0);
        end
        idle(6);
        chk_got(10, {16'd10, 32'd4, 3'b000});
        chk_got(11, {16'd11, 32'd4, 3'b100});

        // Consumer stalled: five frames into a four-entry FIFO.
        stat_ready = 1'b0;
        for (int i = 0; i < 5; i++) drv(0, 64'd0, 8'h00, 2'b00, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            drv(1, 64'h200 + 64'(i), 8'h00, 2'b00, 0, 0, 0);
        idle(6);
        chk("ovf_sticky", {63'd0, stat_overflow}, 64'd1);
        stat_ready = 1'b1;
        idle(8);
        chk_got(12, {16'd12, 32'd0, 3'b000});
        chk_got(15, {16'd15, 32'd0, 3'b000});
        chk("drain_count", 64'(got.size()), 64'd16);

        // Reset in the middle of a frame.
        drv(0, 64'd0, 8'h00, 2'b00, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            drv(1, 64'h300 + 64'(i), 8'hFF, 2'b01, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        lz_be_dp_valid   = 1'b0;
        lfa_be_crc_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drv(0, 64'd0, 8'h00, 2'b00, 1, 0, 0);
        drv(1, 64'h0000_0000_0000_BEEF, 8'h03, 2'b01, 0, 0, 0);
        drv(1, 64'hFEED_0000_0000_0004, 8'hFF, 2'b10, 0, 0, 0);
        idle(5);
        chk_got(16, {16'd0, 32'd2, 3'b000});
        chk("ovf_cleared", {63'd0, stat_overflow}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cr_xp10_decomp_be_frm_tag.md
Name: cr_xp10_decomp_be_frm_tag

Overview:
- Sits directly downstream of the back-end frame checker in the XP10 decompressor.
- Taps the same LZ back-end data stream the checker sees and delays it by exactly the checker's result latency (2 cycles), so the checker's size_error/crc_error pulses line up with the frame-end word.
- Tags that word with an error bit and pushes one per-frame status record into a small ready/valid status FIFO.
- Mirrors the checker's 8-deep trailer FIFO occupancy to flag frames that ended with no trailer, a case the checker silently skips.

Parameters:
STAT_DEPTH, 4, status FIFO entries (power of 2, >=2)
TRL_DEPTH, 8, mirrored trailer FIFO depth; must equal the checker's trailer FIFO depth

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lz_be_dp_valid  in  1  LZ back-end word valid, same stream that feeds the checker
lz_be_dp_data  in  64  word data
lz_be_dp_bytes_valid  in  8  thermometer byte mask
lz_be_dp_data_type  in  2  2'b01 = payload; any other value = frame-end word
lfa_be_crc_valid  in  1  trailer record written into the checker's trailer FIFO
size_error  in  1  checker size result, 1-cycle pulse
crc_error  in  1  checker crc/adler result, 1-cycle pulse
out_valid  out  1  delayed word valid
out_data  out  64  delayed data
out_bytes_valid  out  8  delayed byte mask
out_data_type  out  2  delayed type
out_err  out  1  asserted only on a frame-end word whose frame failed
stat_valid  out  1  status FIFO not empty
stat_ready  in  1  status consumer ready
stat_frm_num  out  16  frame sequence number
stat_bcnt  out  32  payload byte count of the frame
stat_code  out  3  [0] crc_error, [1] size_error, [2] missing trailer
stat_overflow  out  1  sticky: a status record was dropped

Behaviour:
- Reset values: all outputs 0; frm_num 0; byte count 0; trailer count 0; status FIFO empty.
- Data path: two register stages, S1 and S2. No backpressure. out_* at cycle T+2 equals lz_be_dp_* at cycle T. out_valid=0 bubbles are preserved.
- Byte count:
  - On each S1-valid payload word, add the popcount of its thermometer mask: 8'h01->1 ... 8'hFF->8; any non-thermometer mask adds 0.
  - Counter is 32-bit and wraps.
  - An S1-valid frame-end word snapshots the count into S2, then clears it to 0. Frame-end data bytes are not counted.
- Trailer mirror counter trl_cnt (0..TRL_DEPTH):
  - +1 on lfa_be_crc_valid.
  - -1 when an S1-valid frame-end word is present and trl_cnt != 0.
  - Both in the same cycle: net 0.
  - Saturates at TRL_DEPTH; increments at saturation are ignored.
  - An S1 frame-end word with trl_cnt == 0 sets missing=1 in S2.
- Error capture, in the cycle an S2-valid frame-end word is present:
  - code = {missing, size_error, crc_error}.
  - If missing=1, size_error and crc_error are ignored (forced 0); the checker performed no check.
  - out_err = |code.
  - Push {frm_num, snapshot bcnt, code} into the status FIFO.
  - frm_num increments, wrapping 16'hFFFF -> 0.
- Error pulses in any other cycle are ignored.
- Status FIFO:
  - Pop on stat_valid & stat_ready.
  - A push while full is accepted only if a pop happens in the same cycle.
  - Otherwise the record is dropped, frm_num still increments, and stat_overflow sets, sticky until reset.
  - Push into an empty FIFO: stat_valid rises the next cycle (registered, 1-cycle latency). stat_* outputs come from the head entry and hold stable while stat_valid & !stat_ready.
- Back-to-back frame-end words, e.g. empty frames: each is handled independently; byte count 0.
- Reset mid-frame: pipeline, counters and FIFO are cleared; the first word after reset starts a new frame.

Test Plan:
- Two payload words (masks 8'hFF, 8'h07), trailer loaded earlier, frame-end word, no errors -> out_* equals input delayed 2 cycles; status {frm_num 0, bcnt 11, code 3'b000}; out_err 0.
- Same frame with crc_error pulsed in the S2 frame-end cycle -> out_err 1 on the frame-end word only; status code 3'b001, bcnt 11; frm_num 1 on the next frame.
- Frame-end with no prior lfa_be_crc_valid, size_error pulsed -> code 3'b100, size bit masked; trl_cnt stays 0.
- 9 trailers, then 9 one-word frames with mask 8'h0F -> first 8 frames get code 0 and bcnt 4; 9th gets code 3'b100 (saturation at 8).
- stat_ready=0, push 5 frames with STAT_DEPTH=4 -> 4 records held, stat_overflow=1; 5th frame's frm_num 4 skipped; with stat_ready=1 the records drain in order 0..3.
- Assert rst_n low mid-frame after 3 payload words -> all outputs 0; the next frame counts from 0 and its status has frm_num 0.
